// File: rtl/sp_req_queue_if.sv
// Handshake bundle for sp_req_queue: producer push side, consumer pop side
// and the queue status. The master modport is the requester/scratchpad
// side, the slave modport is the queue itself.
// Optional macro SP_REQ_FLUSH_EN adds push_spec, commit and flush.
interface sp_req_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int MAT_W  = 4
);
  localparam int ENTRY_W = 2 + MAT_W + ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               push;
  logic [1:0]         push_type;
  logic [MAT_W-1:0]   push_rd;
  logic [ADDR_W-1:0]  push_payload;
  logic               full;
  logic               pop;
  logic               valid;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
`ifdef SP_REQ_FLUSH_EN
  logic               push_spec;
  logic               commit;
  logic               flush;

  modport master (
    output push, push_type, push_rd, push_payload, pop, push_spec, commit, flush,
    input  full, valid, head, count
  );
  modport slave (
    input  push, push_type, push_rd, push_payload, pop, push_spec, commit, flush,
    output full, valid, head, count
  );
`else
  modport master (
    output push, push_type, push_rd, push_payload, pop,
    input  full, valid, head, count
  );
  modport slave (
    input  push, push_type, push_rd, push_payload, pop,
    output full, valid, head, count
  );
`endif
endinterface

// File: rtl/sp_req_queue.sv
// Scratchpad request queue: a DEPTH-entry FIFO of load/store/gemm requests
// with per-type outstanding counters fed by the consumer's pops and drained
// by completion pulses, plus a sticky protocol-error flag.
// Optional macro SP_REQ_FLUSH_EN adds speculative entries (a contiguous block
// at the tail) that can be committed or flushed.
module sp_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int MAT_W  = 4,
  parameter int OUT_W  = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  sp_req_queue_if.slave    q,
  input  logic             load_complete,
  input  logic             store_complete,
  input  logic             gemm_complete,
  output logic [OUT_W-1:0] out_load,
  output logic [OUT_W-1:0] out_store,
  output logic [OUT_W-1:0] out_gemm,
  output logic             busy,
  output logic             err
);
  localparam int ENTRY_W = 2 + MAT_W + ADDR_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    TYPE_ILLEGAL = 2'b00,
    TYPE_LOAD    = 2'b01,
    TYPE_STORE   = 2'b10,
    TYPE_GEMM    = 2'b11
  } req_type_e;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q [3];
  logic [OUT_W-1:0]   out_d [3];
  logic               err_q, err_d;

  logic [ENTRY_W-1:0] head_entry;
  req_type_e          head_type;
  logic [2:0]         cmp;
  logic               not_empty, is_full;
  logic               pop_stall, pop_ok, push_ok;
  logic               inc, dec;
`ifdef SP_REQ_FLUSH_EN
  logic [DEPTH-1:0]   spec_q, spec_d;
  logic [CNT_W-1:0]   spec_cnt;
`endif

  assign cmp = {gemm_complete, store_complete, load_complete};

  // Next-state: accept/reject decisions, pointers, occupancy, counters, error.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    head_entry = mem_q[rd_ptr_q];
    head_type  = req_type_e'(head_entry[ENTRY_W-1 -: 2]);
    not_empty  = (cnt_q != '0);
    is_full    = (cnt_q == CNT_W'(DEPTH));
    err_d      = err_q;

    // Hold the head while its type's counter is saturated.
    pop_stall = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (head_type == req_type_e'(2'(t + 1)) && out_q[t] == '1) pop_stall = 1'b1;
    end
`ifdef SP_REQ_FLUSH_EN
    if (spec_q[rd_ptr_q]) pop_stall = 1'b1;
`endif
    pop_ok = q.pop && not_empty && !pop_stall;

    // Fullness uses the pre-edge count, so a same-cycle pop never frees space.
    push_ok = q.push && !is_full && (q.push_type != TYPE_ILLEGAL);
    if (q.push && (is_full || q.push_type == TYPE_ILLEGAL)) err_d = 1'b1;

`ifdef SP_REQ_FLUSH_EN
    spec_cnt = '0;
    for (int i = 0; i < DEPTH; i++) spec_cnt = spec_cnt + CNT_W'(spec_q[i]);
    if (q.flush) begin
      push_ok = 1'b0;
    end else if (push_ok && !q.push_spec && spec_cnt != '0) begin
      push_ok = 1'b0;
      err_d   = 1'b1;
    end
`endif

    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

`ifdef SP_REQ_FLUSH_EN
    // Speculative entries sit at the tail, so a flush just rewinds the write side.
    spec_d = spec_q;
    if (q.flush) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(spec_cnt);
      cnt_d    = cnt_q - spec_cnt - CNT_W'(pop_ok);
    end
    if (q.flush || q.commit) spec_d = '0;
    if (push_ok) spec_d[wr_ptr_q] = q.push_spec;
`endif

    // Outstanding counters: pop increments, completion decrements.
    for (int t = 0; t < 3; t++) begin
      inc = pop_ok && (head_type == req_type_e'(2'(t + 1)));
      dec = cmp[t] && (out_q[t] != '0);
      if (cmp[t] && out_q[t] == '0) err_d = 1'b1;
      out_d[t] = out_q[t] + OUT_W'(inc) - OUT_W'(dec);
    end
  end

  // Control state register with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int t = 0; t < 3; t++) out_q[t] <= '0;
`ifdef SP_REQ_FLUSH_EN
      spec_q   <= '0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      for (int t = 0; t < 3; t++) out_q[t] <= out_d[t];
`ifdef SP_REQ_FLUSH_EN
      spec_q   <= spec_d;
`endif
    end
  end

  // Entry storage write port.
  // NOTE: the payload array is not reset; head is masked by valid instead.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {q.push_type, q.push_rd, q.push_payload};
  end

  assign q.valid   = not_empty;
  assign q.full    = is_full;
  assign q.count   = cnt_q;
  assign q.head    = not_empty ? head_entry : '0;
  assign out_load  = out_q[0];
  assign out_store = out_q[1];
  assign out_gemm  = out_q[2];
  assign busy      = not_empty || (out_q[0] != '0) || (out_q[1] != '0) || (out_q[2] != '0);
  assign err       = err_q;

endmodule

// File: tb/tb_sp_req_queue.sv
// Self-checking bench for sp_req_queue (DEPTH=4, ADDR_W=32, MAT_W=4, OUT_W=3).
// A queue-based reference model tracks the expected state; a compare process
// checks every output at each falling edge, and directed steps pin key values.
module tb_sp_req_queue;
  localparam int DEPTH   = 4;
  localparam int OUT_MAX = 7;

  logic CLK = 1'b0;
  logic nRST;
  logic load_complete, store_complete, gemm_complete;
  logic [2:0] out_load, out_store, out_gemm;
  logic busy, err;
  logic push_spec, commit, flush;

  int n_cmp = 0;
  int n_bad = 0;

  sp_req_queue_if #(.DEPTH(4), .ADDR_W(32), .MAT_W(4)) q_if ();

`ifdef SP_REQ_FLUSH_EN
  assign q_if.push_spec = push_spec;
  assign q_if.commit    = commit;
  assign q_if.flush     = flush;
`endif

  sp_req_queue #(.DEPTH(4), .ADDR_W(32), .MAT_W(4), .OUT_W(3)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .q              (q_if),
    .load_complete  (load_complete),
    .store_complete (store_complete),
    .gemm_complete  (gemm_complete),
    .out_load       (out_load),
    .out_store      (out_store),
    .out_gemm       (out_gemm),
    .busy           (busy),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [37:0] e; bit s; } ment_t;
  ment_t mq[$];
  int    out_m [3];
  bit    err_m;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      out_m = '{0, 0, 0};
      err_m = 1'b0;
    end else begin : upd
      int  sz;
      int  nspec;
      int  ht;
      bit  pop_ok;
      bit  push_ok;
      bit [2:0] cv;
      sz    = mq.size();
      nspec = 0;
      foreach (mq[i]) if (mq[i].s) nspec++;
      cv = {gemm_complete, store_complete, load_complete};
      ht = (sz > 0) ? int'(mq[0].e[37:36]) - 1 : 0;
      pop_ok  = q_if.pop && sz > 0 && !mq[0].s && out_m[ht] < OUT_MAX;
      push_ok = q_if.push && sz < DEPTH && q_if.push_type != 2'b00;
      if (q_if.push && (sz == DEPTH || q_if.push_type == 2'b00)) err_m = 1'b1;
      if (flush) push_ok = 1'b0;
      else if (push_ok && !push_spec && nspec > 0) begin
        push_ok = 1'b0;
        err_m   = 1'b1;
      end
      for (int t = 0; t < 3; t++) begin
        if (cv[t]) begin
          if (out_m[t] == 0) err_m = 1'b1;
          else out_m[t]--;
        end
      end
      if (pop_ok) begin
        out_m[ht]++;
        void'(mq.pop_front());
      end
      if (flush) begin
        while (mq.size() > 0 && mq[mq.size()-1].s) void'(mq.pop_back());
      end else if (commit) begin
        foreach (mq[i]) mq[i].s = 1'b0;
      end
      if (push_ok) mq.push_back('{e: {q_if.push_type, q_if.push_rd, q_if.push_payload}, s: push_spec});
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    if (nRST) begin
      check("count", 64'(q_if.count), 64'(mq.size()));
      check("valid", 64'(q_if.valid), 64'(mq.size() != 0));
      check("full",  64'(q_if.full),  64'(mq.size() == DEPTH));
      if (mq.size() > 0) check("head", 64'(q_if.head), 64'(mq[0].e));
      check("out_load",  64'(out_load),  64'(out_m[0]));
      check("out_store", 64'(out_store), 64'(out_m[1]));
      check("out_gemm",  64'(out_gemm),  64'(out_m[2]));
      check("busy", 64'(busy), 64'(mq.size() != 0 || out_m[0] != 0 || out_m[1] != 0 || out_m[2] != 0));
      check("err",  64'(err),  64'(err_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ps, input logic [1:0] ty, input logic [3:0] rd,
                       input logic [31:0] pl, input logic pp, input logic [2:0] cv);
    q_if.push = ps; q_if.push_type = ty; q_if.push_rd = rd; q_if.push_payload = pl;
    q_if.pop = pp;
    load_complete = cv[0]; store_complete = cv[1]; gemm_complete = cv[2];
    @(posedge CLK); #1;
    q_if.push = 1'b0; q_if.push_type = 2'b00; q_if.push_rd = '0; q_if.push_payload = '0;
    q_if.pop = 1'b0;
    load_complete = 1'b0; store_complete = 1'b0; gemm_complete = 1'b0;
  endtask

  task automatic drive_spec(input logic sp, input logic cm, input logic fl,
                            input logic ps, input logic [1:0] ty);
    push_spec = sp; commit = cm; flush = fl;
    drive(ps, ty, 4'd0, 32'h0, 1'b0, 3'b000);
    push_spec = 1'b0; commit = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    q_if.push = 1'b0; q_if.push_type = 2'b00; q_if.push_rd = '0; q_if.push_payload = '0;
    q_if.pop = 1'b0;
    load_complete = 1'b0; store_complete = 1'b0; gemm_complete = 1'b0;
    push_spec = 1'b0; commit = 1'b0; flush = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    check("rst_count", 64'(q_if.count), 64'd0);
    check("rst_valid", 64'(q_if.valid), 64'd0);
    check("rst_full",  64'(q_if.full),  64'd0);
    check("rst_head",  64'(q_if.head),  64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_err",   64'(err),  64'd0);

    // Load then store; pop exposes the store.
    drive(1, 2'b01, 4'd3, 32'h0000_1000, 0, 3'b000);
    drive(1, 2'b10, 4'd5, 32'h0000_2000, 0, 3'b000);
    check("two_count", 64'(q_if.count), 64'd2);
    check("two_head",  64'(q_if.head), 64'({2'b01, 4'd3, 32'h0000_1000}));
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    check("pop_head",  64'(q_if.head), 64'({2'b10, 4'd5, 32'h0000_2000}));
    check("pop_oload", 64'(out_load), 64'd1);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b001);
    check("swap_oload",  64'(out_load),  64'd0);
    check("swap_ostore", 64'(out_store), 64'd1);
    drive(0, 2'b00, 4'd0, 32'h0, 0, 3'b010);

    // Gemm: pop and completion of the same type in one cycle cancel.
    drive(1, 2'b11, 4'd0, 32'h0000_00A5, 0, 3'b000);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    check("gemm_one", 64'(out_gemm), 64'd1);
    drive(1, 2'b11, 4'd1, 32'h0000_005A, 0, 3'b000);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b100);
    check("gemm_hold", 64'(out_gemm), 64'd1);
    drive(0, 2'b00, 4'd0, 32'h0, 0, 3'b100);
    check("gemm_zero", 64'(out_gemm), 64'd0);
    check("gemm_busy", 64'(busy), 64'd0);
    check("gemm_err",  64'(err), 64'd0);

    // Spurious completion and illegal type.
    drive(0, 2'b00, 4'd0, 32'h0, 0, 3'b010);
    check("spur_ostore", 64'(out_store), 64'd0);
    check("spur_err",    64'(err), 64'd1);
    drive(1, 2'b00, 4'd2, 32'h0000_0300, 0, 3'b000);
    check("ill_count", 64'(q_if.count), 64'd0);

    // Fill, then push into a full queue while popping.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 2'b01, 4'(i), 32'(i), 0, 3'b000);
    check("fill_full", 64'(q_if.full), 64'd1);
    drive(1, 2'b10, 4'd9, 32'h0000_0099, 1, 3'b000);
    check("ovf_count", 64'(q_if.count), 64'd3);
    check("ovf_err",   64'(err), 64'd1);

    // Three queued, out_load=2, then reset between edges.
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    drive(1, 2'b01, 4'd7, 32'h0000_0777, 0, 3'b000);
    check("pre_count", 64'(q_if.count), 64'd3);
    check("pre_oload", 64'(out_load), 64'd2);
    #2 nRST = 1'b0;
    #1;
    check("arst_count", 64'(q_if.count), 64'd0);
    check("arst_valid", 64'(q_if.valid), 64'd0);
    check("arst_head",  64'(q_if.head), 64'd0);
    check("arst_oload", 64'(out_load), 64'd0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_err",   64'(err), 64'd0);
    load_complete = 1'b1;
    @(posedge CLK); #1;
    load_complete = 1'b0;
    nRST = 1'b1;
    drive(0, 2'b00, 4'd0, 32'h0, 0, 3'b000);
    check("post_oload", 64'(out_load), 64'd0);
    check("post_err",   64'(err), 64'd0);

    // Push+pop on empty, then saturate out_load.
    drive(1, 2'b01, 4'd0, 32'h0000_0010, 1, 3'b000);
    check("empty_pp_count", 64'(q_if.count), 64'd1);
    check("empty_pp_oload", 64'(out_load), 64'd0);
    for (int i = 1; i < 9; i++) drive(1, 2'b01, 4'(i), 32'(16 + i), 1, 3'b000);
    check("sat_oload", 64'(out_load), 64'd7);
    check("sat_count", 64'(q_if.count), 64'd2);
    check("sat_valid", 64'(q_if.valid), 64'd1);
    drive(0, 2'b00, 4'd0, 32'h0, 0, 3'b001);
    check("sat_dec", 64'(out_load), 64'd6);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    check("sat_pop_oload", 64'(out_load), 64'd7);
    check("sat_pop_count", 64'(q_if.count), 64'd1);
    check("sat_err", 64'(err), 64'd0);

`ifdef SP_REQ_FLUSH_EN
    // Flush drops the speculative tail; the next push reuses slot 2.
    do_reset();
    drive_spec(0, 0, 0, 1, 2'b01);
    drive_spec(0, 0, 0, 1, 2'b01);
    drive_spec(1, 0, 0, 1, 2'b10);
    drive_spec(1, 0, 0, 1, 2'b10);
    drive_spec(0, 0, 1, 0, 2'b00);
    check("flush_count", 64'(q_if.count), 64'd2);
    drive_spec(0, 0, 0, 1, 2'b11);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    drive(0, 2'b00, 4'd0, 32'h0, 1, 3'b000);
    check("flush_slot2", 64'(q_if.head), 64'({2'b11, 4'd0, 32'h0}));
    // Commit first: flush then has nothing to remove.
    do_reset();
    drive_spec(0, 0, 0, 1, 2'b01);
    drive_spec(0, 0, 0, 1, 2'b01);
    drive_spec(1, 0, 0, 1, 2'b10);
    drive_spec(1, 0, 0, 1, 2'b10);
    drive_spec(0, 1, 0, 0, 2'b00);
    drive_spec(0, 0, 1, 0, 2'b00);
    check("commit_count", 64'(q_if.count), 64'd4);
    check("commit_err",   64'(err), 64'd0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
